// File: rtl/secded_read_decoder_pkg.sv
// Shared SECDED definitions: codeword geometry, error classes and the port tag type.
package secded_read_decoder_pkg;

  localparam int unsigned D_W = 32;
  localparam int unsigned P_W = 6;
  localparam int unsigned C_W = D_W + P_W + 1;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SEC  = 2'd1,
    ERR_DED  = 2'd2
  } err_type_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_indicator_e;

  // Power-of-two Hamming positions carry parity rather than data.
  function automatic logic is_pow2(int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/secded_read_decoder_syndrome.sv
// Combinational Hamming check: syndrome over positions 1..C_W-1 and overall parity.
module secded_syndrome #(
  parameter int unsigned C_W = 39,
  parameter int unsigned P_W = 6
) (
  input  logic [C_W-1:0] code_i,
  output logic [P_W-1:0] syn_o,
  output logic           par_o
);

  logic [C_W-1:0] sh;

  always_comb begin
    syn_o = '0;
    sh    = '0;
    for (int unsigned i = 1; i < C_W; i++) begin
      sh = code_i >> i;
      if (sh[0]) begin
        syn_o = syn_o ^ P_W'(i);
      end
    end
    par_o = ^code_i;
  end

endmodule

// File: rtl/secded_read_decoder.sv
// Two-stage SECDED read checker: corrects single errors, flags doubles, counts both and
// issues a scrub write-back request carrying the corrected codeword.
module secded_read_decoder #(
  parameter int unsigned D_W   = secded_read_decoder_pkg::D_W,
  parameter int unsigned A_W   = 10,
  parameter int unsigned P_W   = secded_read_decoder_pkg::P_W,
  parameter int unsigned C_W   = secded_read_decoder_pkg::C_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_valid_i,
  input  logic [C_W-1:0]   rd_code_i,
  input  logic [A_W-1:0]   rd_addr_i,
  input  logic             rd_port_i,
  output logic             dout_valid_o,
  output logic [D_W-1:0]   dout_o,
  output logic [A_W-1:0]   dout_addr_o,
  output logic             dout_port_o,
  output logic [1:0]       err_o,
  output logic             scrub_req_o,
  output logic [A_W-1:0]   scrub_addr_o,
  output logic [C_W-1:0]   scrub_code_o,
  input  logic             scrub_ack_i,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] sec_cnt_o,
  output logic [CNT_W-1:0] ded_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  import secded_read_decoder_pkg::*;

  localparam logic [P_W-1:0]   MaxPos = P_W'(C_W - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  function automatic logic [D_W-1:0] extract_data(logic [C_W-1:0] code);
    logic [D_W-1:0] d;
    logic [C_W-1:0] sh;
    d = '0;
    for (int unsigned i = 1; i < C_W; i++) begin
      if (!is_pow2(i)) begin
        sh = code >> i;
        d  = {sh[0], d[D_W-1:1]};
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
    return (c == CntMax) ? c : c + 1'b1;
  endfunction

  // Stage 1 registers
  logic            s1_valid_q;
  logic [C_W-1:0]  s1_code_q;
  logic [A_W-1:0]  s1_addr_q;
  port_indicator_e s1_port_q;

  // Stage 2 / output registers
  logic             dout_valid_q;
  logic [D_W-1:0]   dout_q;
  logic [A_W-1:0]   dout_addr_q;
  logic             dout_port_q;
  err_type_e        err_q;
  logic             scrub_req_q;
  logic [A_W-1:0]   scrub_addr_q;
  logic [C_W-1:0]   scrub_code_q;
  logic [CNT_W-1:0] sec_cnt_q, ded_cnt_q, drop_cnt_q;

  logic [P_W-1:0] syn_s;
  logic           syn_p;
  err_type_e      err_d;
  logic [C_W-1:0] corr_code_d;
  logic [D_W-1:0] dout_d;
  logic           sec_hit, ded_hit, scrub_load, scrub_drop;

  secded_syndrome #(
    .C_W(C_W),
    .P_W(P_W)
  ) u_syndrome (
    .code_i(s1_code_q),
    .syn_o (syn_s),
    .par_o (syn_p)
  );

  always_comb begin
    err_d       = ERR_NONE;
    corr_code_d = s1_code_q;
    if (syn_p) begin
      if (syn_s == '0) begin
        // Only the overall parity bit is wrong.
        err_d       = ERR_SEC;
        corr_code_d = s1_code_q ^ C_W'(1);
      end else if (syn_s <= MaxPos) begin
        err_d       = ERR_SEC;
        corr_code_d = s1_code_q ^ (C_W'(1) << syn_s);
      end else begin
        err_d = ERR_DED;
      end
    end else if (syn_s != '0) begin
      err_d = ERR_DED;
    end
    dout_d     = extract_data(corr_code_d);
    sec_hit    = s1_valid_q && (err_d == ERR_SEC);
    ded_hit    = s1_valid_q && (err_d == ERR_DED);
    scrub_load = sec_hit && (!scrub_req_q || scrub_ack_i);
    scrub_drop = sec_hit && scrub_req_q && !scrub_ack_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_addr_q    <= '0;
      s1_port_q    <= PORT_A;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_addr_q  <= '0;
      dout_port_q  <= 1'b0;
      err_q        <= ERR_NONE;
      scrub_req_q  <= 1'b0;
      scrub_addr_q <= '0;
      scrub_code_q <= '0;
      sec_cnt_q    <= '0;
      ded_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      s1_valid_q <= rd_valid_i;
      if (rd_valid_i) begin
        s1_code_q <= rd_code_i;
        s1_addr_q <= rd_addr_i;
        s1_port_q <= port_indicator_e'(rd_port_i);
      end

      dout_valid_q <= s1_valid_q;
      err_q        <= s1_valid_q ? err_d : ERR_NONE;
      if (s1_valid_q) begin
        dout_q      <= dout_d;
        dout_addr_q <= s1_addr_q;
        dout_port_q <= s1_port_q;
      end

      if (scrub_load) begin
        scrub_req_q  <= 1'b1;
        scrub_addr_q <= s1_addr_q;
        scrub_code_q <= corr_code_d;
      end else if (scrub_ack_i) begin
        scrub_req_q <= 1'b0;
      end

      if (cnt_clr_i) begin
        sec_cnt_q  <= '0;
        ded_cnt_q  <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (sec_hit)    sec_cnt_q  <= sat_inc(sec_cnt_q);
        if (ded_hit)    ded_cnt_q  <= sat_inc(ded_cnt_q);
        if (scrub_drop) drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  assign dout_valid_o = dout_valid_q;
  assign dout_o       = dout_q;
  assign dout_addr_o  = dout_addr_q;
  assign dout_port_o  = dout_port_q;
  assign err_o        = err_q;
  assign scrub_req_o  = scrub_req_q;
  assign scrub_addr_o = scrub_addr_q;
  assign scrub_code_o = scrub_code_q;
  assign sec_cnt_o    = sec_cnt_q;
  assign ded_cnt_o    = ded_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_secded_read_decoder.sv
// Self-checking bench: directed plan steps plus random traffic against a word-level model.
module tb_secded_read_decoder;
  import secded_read_decoder_pkg::*;

  localparam int CW      = 39;
  localparam int DW      = 32;
  localparam int AW      = 10;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            rd_valid_i;
  logic [CW-1:0]   rd_code_i;
  logic [AW-1:0]   rd_addr_i;
  logic            rd_port_i;
  logic            dout_valid_o;
  logic [DW-1:0]   dout_o;
  logic [AW-1:0]   dout_addr_o;
  logic            dout_port_o;
  logic [1:0]      err_o;
  logic            scrub_req_o;
  logic [AW-1:0]   scrub_addr_o;
  logic [CW-1:0]   scrub_code_o;
  logic            scrub_ack_i;
  logic            cnt_clr_i;
  logic [CNTW-1:0] sec_cnt_o, ded_cnt_o, drop_cnt_o;

  always #5 clk = ~clk;

  secded_read_decoder #(
    .CNT_W(CNTW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_valid_i  (rd_valid_i),
    .rd_code_i   (rd_code_i),
    .rd_addr_i   (rd_addr_i),
    .rd_port_i   (rd_port_i),
    .dout_valid_o(dout_valid_o),
    .dout_o      (dout_o),
    .dout_addr_o (dout_addr_o),
    .dout_port_o (dout_port_o),
    .err_o       (err_o),
    .scrub_req_o (scrub_req_o),
    .scrub_addr_o(scrub_addr_o),
    .scrub_code_o(scrub_code_o),
    .scrub_ack_i (scrub_ack_i),
    .cnt_clr_i   (cnt_clr_i),
    .sec_cnt_o   (sec_cnt_o),
    .ded_cnt_o   (ded_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  typedef struct {
    bit            v;
    logic [AW-1:0] addr;
    logic          port;
    int            err;
    logic [DW-1:0] data;
    logic [CW-1:0] clean;
  } word_t;

  int n_chk = 0;
  int n_err = 0;

  word_t         nil, st1;
  bit            m_dv, m_req;
  int            m_err, m_sec, m_ded, m_drop;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr, m_saddr;
  logic          m_port;
  logic [CW-1:0] m_scode;

  function automatic bit pow2(input int i);
    return (i != 0) && ((i & (i - 1)) == 0);
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] data);
    logic [CW-1:0] c;
    int syn, k;
    c = '0; syn = 0; k = 0;
    for (int i = 1; i < CW; i++) begin
      if (!pow2(i)) begin
        if (((data >> k) & 32'd1) != 0) begin
          c   = c | (CW'(1) << i);
          syn = syn ^ i;
        end
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      if (((syn >> j) & 1) != 0) c = c | (CW'(1) << (1 << j));
    end
    if (^c) c = c | CW'(1);
    return c;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    logic [CW-1:0] t;
    int k;
    d = '0; k = 0;
    for (int i = 1; i < CW; i++) begin
      if (!pow2(i)) begin
        t = c >> i;
        if (t[0]) d = d | (DW'(1) << k);
        k++;
      end
    end
    return d;
  endfunction

  function automatic int sat(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected class from the number of injected flips; 3-flip masks are only used with an
  // index XOR beyond the last codeword position, which must read as a double error.
  task automatic mk(input logic [DW-1:0] data, input logic [AW-1:0] addr, input logic port,
                    input logic [CW-1:0] flips, output word_t w, output logic [CW-1:0] code);
    int n;
    w.v     = 1'b1;
    w.addr  = addr;
    w.port  = port;
    w.clean = encode(data);
    code    = w.clean ^ flips;
    n       = $countones(flips);
    if (n == 0) begin
      w.err = 0; w.data = data;
    end else if (n == 1) begin
      w.err = 1; w.data = data;
    end else begin
      w.err = 2; w.data = extract(code);
    end
  endtask

  task automatic cycle(input word_t w, input logic [CW-1:0] code, input bit ack, input bit clr,
                       input bit r);
    word_t comp;
    bit    drop_ev;
    rd_valid_i  = w.v;
    rd_code_i   = code;
    rd_addr_i   = w.addr;
    rd_port_i   = w.port;
    scrub_ack_i = ack;
    cnt_clr_i   = clr;
    rst         = r;
    @(posedge clk);
    comp = st1;
    st1  = w;
    if (r) begin
      st1.v = 1'b0;
      m_dv = 0; m_err = 0; m_data = '0; m_addr = '0; m_port = 1'b0;
      m_req = 0; m_saddr = '0; m_scode = '0; m_sec = 0; m_ded = 0; m_drop = 0;
    end else begin
      drop_ev = 0;
      m_dv  = comp.v;
      m_err = comp.v ? comp.err : 0;
      if (comp.v) begin
        m_data = comp.data; m_addr = comp.addr; m_port = comp.port;
      end
      if (comp.v && comp.err == 1) begin
        if (!m_req || ack) begin
          m_req = 1; m_saddr = comp.addr; m_scode = comp.clean;
        end else begin
          drop_ev = 1;
        end
      end else if (ack) begin
        m_req = 0;
      end
      if (clr) begin
        m_sec = 0; m_ded = 0; m_drop = 0;
      end else begin
        if (comp.v && comp.err == 1) m_sec = sat(m_sec);
        if (comp.v && comp.err == 2) m_ded = sat(m_ded);
        if (drop_ev) m_drop = sat(m_drop);
      end
    end
    #1;
    chk("dout_valid", 64'(dout_valid_o), 64'(m_dv));
    chk("err", 64'(err_o), 64'(m_err));
    if (m_dv) begin
      chk("dout", 64'(dout_o), 64'(m_data));
      chk("dout_addr", 64'(dout_addr_o), 64'(m_addr));
      chk("dout_port", 64'(dout_port_o), 64'(m_port));
    end
    chk("scrub_req", 64'(scrub_req_o), 64'(m_req));
    if (m_req) begin
      chk("scrub_addr", 64'(scrub_addr_o), 64'(m_saddr));
      chk("scrub_code", 64'(scrub_code_o), 64'(m_scode));
    end
    chk("sec_cnt", 64'(sec_cnt_o), 64'(m_sec));
    chk("ded_cnt", 64'(ded_cnt_o), 64'(m_ded));
    chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(nil, '0, ack, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dv"}, 64'(dout_valid_o), 64'd0);
    chk({tag, "_dout"}, 64'(dout_o), 64'd0);
    chk({tag, "_addr"}, 64'(dout_addr_o), 64'd0);
    chk({tag, "_port"}, 64'(dout_port_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_sreq"}, 64'(scrub_req_o), 64'd0);
    chk({tag, "_saddr"}, 64'(scrub_addr_o), 64'd0);
    chk({tag, "_scode"}, 64'(scrub_code_o), 64'd0);
    chk({tag, "_cnts"}, 64'({sec_cnt_o, ded_cnt_o, drop_cnt_o}), 64'd0);
  endtask

  initial begin
    word_t         w;
    logic [CW-1:0] c, mask;
    int            p1, p2, nf;
    bit            ack, clr;

    nil.v = 1'b0; nil.addr = '0; nil.port = 1'b0; nil.err = 0; nil.data = '0; nil.clean = '0;
    st1 = nil;

    cycle(nil, '0, 1'b0, 1'b0, 1'b1);
    cycle(nil, '0, 1'b0, 1'b0, 1'b1);
    chk_zero("reset");

    // Clean word
    mk(32'hDEADBEEF, 10'h03A, PORT_B, '0, w, c);
    cycle(w, c, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Single data-position error, request held until ack
    mk(32'hDEADBEEF, 10'h03A, PORT_B, CW'(1) << 12, w, c);
    cycle(w, c, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Overall parity bit wrong
    mk(32'h00000001, 10'h011, PORT_A, CW'(1), w, c);
    cycle(w, c, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Double error
    mk(32'h12345678, 10'h005, PORT_A, (CW'(1) << 3) | (CW'(1) << 20), w, c);
    cycle(w, c, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Syndrome 33^16^8 = 57, beyond the codeword, with odd parity
    mk(32'hCAFEF00D, 10'h0F0, PORT_B, (CW'(1) << 33) | (CW'(1) << 16) | (CW'(1) << 8), w, c);
    cycle(w, c, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Back-to-back singles with no ack, then ack coinciding with a fourth
    for (int a = 1; a <= 3; a++) begin
      mk($urandom(), AW'(a), 1'b0, CW'(1) << $urandom_range(0, CW - 1), w, c);
      cycle(w, c, 1'b0, 1'b0, 1'b0);
    end
    idle(1, 1'b0);
    mk($urandom(), AW'(4), 1'b1, CW'(1) << $urandom_range(0, CW - 1), w, c);
    cycle(w, c, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Counter saturation, then clear racing an increment
    for (int i = 0; i < 20; i++) begin
      mk($urandom(), AW'(i), 1'b0, CW'(1) << $urandom_range(0, CW - 1), w, c);
      cycle(w, c, 1'b1, 1'b0, 1'b0);
    end
    idle(2, 1'b1);
    mk($urandom(), 10'h100, 1'b1, CW'(1) << 7, w, c);
    cycle(w, c, 1'b1, 1'b0, 1'b0);
    cycle(nil, '0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b0);

    // Reset while a word is in flight
    mk(32'hA5A5A5A5, 10'h2AA, PORT_B, CW'(1) << 5, w, c);
    cycle(w, c, 1'b0, 1'b0, 1'b0);
    cycle(nil, '0, 1'b0, 1'b0, 1'b1);
    chk_zero("rst_flush");
    idle(2, 1'b0);
    chk_zero("rst_after");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ack = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 7) begin
        nf = $urandom_range(0, 19);
        p1 = $urandom_range(0, CW - 1);
        p2 = (p1 + $urandom_range(1, CW - 1)) % CW;
        if (nf < 10)      mask = '0;
        else if (nf < 17) mask = CW'(1) << p1;
        else              mask = (CW'(1) << p1) | (CW'(1) << p2);
        mk($urandom(), AW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), mask, w, c);
        cycle(w, c, ack, clr, 1'b0);
      end else begin
        cycle(nil, '0, ack, clr, 1'b0);
      end
    end
    idle(3, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
